// File: rtl/fan_pwm_driver.sv
// fan_pwm_driver
//
// Turns a registered fan speed code into a single PWM output for the fan
// power stage. Each speed code maps to a duty level. Starting from off
// applies a full-duty spin-up kick. Moves between levels are ramped by a
// fixed step, with one step per PWM period.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   speed_set  qualifier: fan_speed is captured into the target when high
//   fan_speed  00 off, 01 low, 10 med, 11 high
//   pwm_out    registered PWM output to the fan driver
//   duty       duty currently applied (high cycles per period)
//   drv_state  00 OFF, 01 KICK, 10 RAMP, 11 HOLD
//   at_target  applied duty equals the mapped target and state is OFF/HOLD
module fan_pwm_driver #(
    parameter int PWM_PERIOD   = 100,
    parameter int DUTY_LOW     = 30,
    parameter int DUTY_MED     = 60,
    parameter int DUTY_HIGH    = 100,
    parameter int RAMP_STEP    = 10,
    parameter int KICK_PERIODS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       speed_set,
    input  logic [1:0] fan_speed,
    output logic       pwm_out,
    output logic [7:0] duty,
    output logic [1:0] drv_state,
    output logic       at_target
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_KICK = 2'b01,
        ST_RAMP = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    localparam logic [7:0] PERIOD_FULL = 8'(PWM_PERIOD);
    localparam logic [7:0] PERIOD_LAST = 8'(PWM_PERIOD - 1);
    localparam logic [7:0] STEP        = 8'(RAMP_STEP);
    localparam logic [7:0] LVL_LOW     = 8'(DUTY_LOW);
    localparam logic [7:0] LVL_MED     = 8'(DUTY_MED);
    localparam logic [7:0] LVL_HIGH    = 8'(DUTY_HIGH);
    localparam bit         KICK_EN     = (KICK_PERIODS > 0);
    // Only consulted when the kick is enabled, so the wrap at KICK_PERIODS=0
    // never matters.
    localparam logic [7:0] KICK_LAST   = 8'(KICK_PERIODS - 1);

    state_t     state_p0, state_nx;
    logic [7:0] cnt_p0, cnt_nx;
    logic [7:0] duty_p0, duty_nx;
    logic [7:0] target_p0;
    logic [7:0] kick_p0, kick_nx;
    logic       pwm_p0;
    logic       boundary;
    logic [7:0] stepped;
    state_t     settled;

    // Speed code to duty level.
    function automatic logic [7:0] map_speed(input logic [1:0] code);
        case (code)
            2'b01:   return LVL_LOW;
            2'b10:   return LVL_MED;
            2'b11:   return LVL_HIGH;
            default: return 8'd0;
        endcase
    endfunction

    // One ramp step from cur toward tgt, clamped so the step never overshoots.
    // The sums use 9 bits so that duty + step cannot wrap near 255.
    function automatic logic [7:0] ramp_step(input logic [7:0] cur,
                                             input logic [7:0] tgt);
        logic [8:0] up_sum;
        logic [8:0] dn_lim;
        up_sum = {1'b0, cur} + {1'b0, STEP};
        dn_lim = {1'b0, tgt} + {1'b0, STEP};
        if (tgt > cur) begin
            return (up_sum >= {1'b0, tgt}) ? tgt : up_sum[7:0];
        end else if ({1'b0, cur} <= dn_lim) begin
            return tgt;
        end else begin
            return cur - STEP;
        end
    endfunction

    // State that follows a ramp step landing on duty d.
    function automatic state_t settle(input logic [7:0] d,
                                      input logic [7:0] tgt);
        if ((d == tgt) && (tgt != 8'd0)) begin
            return ST_HOLD;
        end else if ((d == 8'd0) && (tgt == 8'd0)) begin
            return ST_OFF;
        end else begin
            return ST_RAMP;
        end
    endfunction

    assign boundary = (cnt_p0 == PERIOD_LAST);
    assign stepped  = ramp_step(duty_p0, target_p0);
    assign settled  = settle(stepped, target_p0);

    always_comb begin
        state_nx = state_p0;
        duty_nx  = duty_p0;
        kick_nx  = kick_p0;
        cnt_nx   = boundary ? 8'd0 : cnt_p0 + 8'd1;

        // Duty, state and kick counter only ever move on a period boundary,
        // so each period is emitted with a single consistent duty.
        if (boundary) begin
            case (state_p0)
                ST_OFF: begin
                    if (target_p0 != 8'd0) begin
                        if (KICK_EN) begin
                            state_nx = ST_KICK;
                            duty_nx  = PERIOD_FULL;
                            kick_nx  = 8'd0;
                        end else begin
                            state_nx = settled;
                            duty_nx  = stepped;
                        end
                    end else begin
                        duty_nx = 8'd0;
                    end
                end
                ST_KICK: begin
                    if (kick_p0 == KICK_LAST) begin
                        if (target_p0 != 8'd0) begin
                            // The motor is already spinning: jump straight
                            // to the requested level.
                            state_nx = ST_HOLD;
                            duty_nx  = target_p0;
                        end else begin
                            // Cancelled during the kick: start descending
                            // from full duty; the first step lands one
                            // period later.
                            state_nx = ST_RAMP;
                            duty_nx  = PERIOD_FULL;
                        end
                    end else begin
                        kick_nx = kick_p0 + 8'd1;
                    end
                end
                ST_RAMP, ST_HOLD: begin
                    // A HOLD whose target moved takes its first step on the
                    // same boundary. A HOLD that is still on target steps by
                    // zero and stays in HOLD.
                    state_nx = settled;
                    duty_nx  = stepped;
                end
                default: begin
                    state_nx = ST_OFF;
                    duty_nx  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0  <= ST_OFF;
            cnt_p0    <= 8'd0;
            duty_p0   <= 8'd0;
            target_p0 <= 8'd0;
            kick_p0   <= 8'd0;
            pwm_p0    <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            cnt_p0   <= cnt_nx;
            duty_p0  <= duty_nx;
            kick_p0  <= kick_nx;
            if (speed_set) begin
                target_p0 <= map_speed(fan_speed);
            end
            // Compare the next-cycle values so that the output lines up with
            // cnt. Full duty then stays high across the wrap without a glitch.
            pwm_p0 <= (cnt_nx < duty_nx);
        end
    end

    assign pwm_out   = pwm_p0;
    assign duty      = duty_p0;
    assign drv_state = state_p0;
    assign at_target = ((state_p0 == ST_OFF) || (state_p0 == ST_HOLD)) &&
                       (duty_p0 == target_p0);

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Testbench for fan_pwm_driver, using the default parameters.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge. Edge numbers below count rising edges after reset release.
// A period boundary is therefore every 100th edge.
module tb_fan_pwm_driver;

    logic       clk;
    logic       reset;
    logic       speed_set;
    logic [1:0] fan_speed;
    logic       pwm_out;
    logic [7:0] duty;
    logic [1:0] drv_state;
    logic       at_target;

    fan_pwm_driver dut (
        .clk       (clk),
        .reset     (reset),
        .speed_set (speed_set),
        .fan_speed (fan_speed),
        .pwm_out   (pwm_out),
        .duty      (duty),
        .drv_state (drv_state),
        .at_target (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] fan;
        int         exp_duty;
        int         exp_state;
    } row_t;

    typedef struct {
        int duty;
        int state;
    } exp_t;

    row_t up_rows  [7];
    row_t dn_rows  [10];
    row_t rev_rows [10];
    exp_t exp_q [$];

    int tests;
    int fails;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count the high cycles of pwm_out over n falling-edge samples.
    task automatic measure(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            highs += int'(pwm_out);
            @(negedge clk);
        end
    endtask

    // Issue a speed command at the start of a period. Queue what the next
    // boundary must produce. Then run to that boundary and compare.
    task automatic run_row(input row_t r, input string tag, input int idx);
        exp_t e;
        speed_set = 1'b1;
        fan_speed = r.fan;
        exp_q.push_back('{duty: r.exp_duty, state: r.exp_state});
        tick(100);
        e = exp_q.pop_front();
        check($sformatf("%s[%0d].duty", tag, idx), int'(duty), e.duty);
        check($sformatf("%s[%0d].state", tag, idx), int'(drv_state), e.state);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        tests = 0;
        fails = 0;

        // HOLD at 30 to full speed: +10 per boundary, HOLD once 100 is reached.
        for (int i = 0; i < 7; i++)
            up_rows[i] = '{fan: 2'b11, exp_duty: 40 + 10 * i,
                           exp_state: (i == 6) ? 3 : 2};
        // HOLD at 100 to off: -10 per boundary, OFF once 0 is reached.
        for (int i = 0; i < 10; i++)
            dn_rows[i] = '{fan: 2'b00, exp_duty: 90 - 10 * i,
                           exp_state: (i == 9) ? 0 : 2};
        // A reversal mid-ramp, then down to off without any kick.
        rev_rows[0] = '{fan: 2'b00, exp_duty: 30, exp_state: 2};
        rev_rows[1] = '{fan: 2'b10, exp_duty: 40, exp_state: 2};
        rev_rows[2] = '{fan: 2'b10, exp_duty: 50, exp_state: 2};
        rev_rows[3] = '{fan: 2'b10, exp_duty: 60, exp_state: 3};
        for (int i = 4; i < 10; i++)
            rev_rows[i] = '{fan: 2'b00, exp_duty: 50 - 10 * (i - 4),
                            exp_state: (i == 9) ? 0 : 2};

        reset     = 1'b0;
        speed_set = 1'b0;
        fan_speed = 2'b00;
        tick(3);
        check("rst.pwm", int'(pwm_out), 0);
        check("rst.duty", int'(duty), 0);
        check("rst.state", int'(drv_state), 0);
        check("rst.at_target", int'(at_target), 1);
        reset = 1'b1;

        // Idle after reset, no speed command.
        measure(500, h);
        check("idle.pwm_highs", h, 0);
        check("idle.duty", int'(duty), 0);
        check("idle.state", int'(drv_state), 0);
        check("idle.at_target", int'(at_target), 1);

        // Low speed from off: a 4-period kick, then HOLD at 30.
        speed_set = 1'b1;
        fan_speed = 2'b01;
        tick(99);
        check("kick.pre_state", int'(drv_state), 0);
        tick(1);
        check("kick.state", int'(drv_state), 1);
        check("kick.duty", int'(duty), 100);
        measure(400, h);
        check("kick.pwm_highs", h, 400);
        check("low.state", int'(drv_state), 3);
        check("low.duty", int'(duty), 30);
        check("low.at_target", int'(at_target), 1);
        measure(100, h);
        check("low.pwm_highs_p1", h, 30);
        measure(100, h);
        check("low.pwm_highs_p2", h, 30);

        // Ramp up to full speed.
        foreach (up_rows[i]) run_row(up_rows[i], "up", i);
        measure(100, h);
        check("high.pwm_highs", h, 100);

        // Ramp down to off.
        foreach (dn_rows[i]) run_row(dn_rows[i], "down", i);
        measure(100, h);
        check("off.pwm_highs", h, 0);
        check("off.at_target", int'(at_target), 1);

        // Back to HOLD at 30 (kick again), then stale inputs held off.
        speed_set = 1'b1;
        fan_speed = 2'b01;
        tick(500);
        check("s5.hold_duty", int'(duty), 30);
        check("s5.hold_state", int'(drv_state), 3);
        speed_set = 1'b0;
        fan_speed = 2'b10;
        tick(1000);
        check("s5.ignored_duty", int'(duty), 30);
        check("s5.ignored_state", int'(drv_state), 3);
        tick(50);
        speed_set = 1'b1;
        tick(1);
        speed_set = 1'b0;
        tick(48);
        check("s5.midperiod_duty", int'(duty), 30);
        check("s5.midperiod_at_target", int'(at_target), 0);
        tick(1);
        check("s5.step_duty", int'(duty), 40);
        check("s5.step_state", int'(drv_state), 2);

        foreach (rev_rows[i]) run_row(rev_rows[i], "rev", i);

        // Kick again, then pull reset in the middle of the second kick period.
        speed_set = 1'b1;
        fan_speed = 2'b01;
        tick(100);
        check("s6.kick_state", int'(drv_state), 1);
        tick(137);
        check("s6.pwm_before_reset", int'(pwm_out), 1);
        reset = 1'b0;
        #1;
        check("s6.async_pwm", int'(pwm_out), 0);
        check("s6.async_duty", int'(duty), 0);
        check("s6.async_state", int'(drv_state), 0);
        check("s6.async_at_target", int'(at_target), 1);
        speed_set = 1'b0;
        fan_speed = 2'b00;
        tick(2);
        reset = 1'b1;
        measure(500, h);
        check("s6.idle_pwm_highs", h, 0);
        check("s6.idle_duty", int'(duty), 0);
        check("s6.idle_state", int'(drv_state), 0);
        check("s6.idle_at_target", int'(at_target), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fan_pwm_driver.md
Name: fan_pwm_driver

Overview:
Downstream stage of the fan speed controller. Consumes the 2-bit fan speed code and its speed_set qualifier, and produces a single PWM output that drives the fan power stage.
- Each speed code maps to a parameterised duty cycle.
- A full-duty spin-up kick is applied when starting from off.
- Duty ramps between levels in fixed steps, one step per PWM period, to limit inrush and acoustic steps.

Parameters:
PWM_PERIOD, 100, clock cycles per PWM period (2..255)
DUTY_LOW, 30, high cycles per period for speed code 01 (≤ PWM_PERIOD)
DUTY_MED, 60, high cycles per period for speed code 10 (≤ PWM_PERIOD)
DUTY_HIGH, 100, high cycles per period for speed code 11 (≤ PWM_PERIOD)
RAMP_STEP, 10, max duty change per period boundary (≥ 1)
KICK_PERIODS, 4, periods at full duty on start from off (0 = kick disabled)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
speed_set  input  1  fan_speed valid qualifier
fan_speed  input  2  00 off, 01 low, 10 med, 11 high
pwm_out  output  1  registered PWM to fan driver
duty  output  8  duty currently applied (high cycles per period)
drv_state  output  2  00 OFF, 01 KICK, 10 RAMP, 11 HOLD
at_target  output  1  duty equals mapped target and state is OFF or HOLD

Behaviour:
- Reset (reset=0, async): cnt=0, duty=0, target=0, kick_cnt=0, state OFF, pwm_out=0, at_target=1. Takes effect immediately, including mid-kick or mid-ramp.
- target register: on every clock edge with speed_set=1, target <= map(fan_speed), where 00→0, 01→DUTY_LOW, 10→DUTY_MED, 11→DUTY_HIGH. With speed_set=0, target holds its previous value.
- cnt: free-running 0..PWM_PERIOD-1, wraps to 0.
- Boundary event: the clock edge where cnt==PWM_PERIOD-1. Only at a boundary do duty, state and kick_cnt change. Changes to target mid-period have no effect until the next boundary. Each boundary decision uses the target value registered before that edge.
- pwm_out <= (cnt_next < duty_next), registered.
  - Each period has exactly duty high cycles, starting at cnt==0 and aligned one cycle after cnt.
  - duty=0 gives constant low; duty=PWM_PERIOD gives constant high with no glitch across the boundary.
- State transitions at a boundary:
  - OFF, target>0, KICK_PERIODS>0 → KICK; duty=PWM_PERIOD; kick_cnt=0.
  - OFF, target>0, KICK_PERIODS=0 → RAMP; duty steps up from 0.
  - OFF, target=0 → stay OFF; duty=0.
  - KICK: kick_cnt increments each boundary. At the boundary where kick_cnt==KICK_PERIODS-1: if target>0, go to HOLD with duty=target (direct jump, no ramp); if target=0, go to RAMP and step down from PWM_PERIOD.
  - RAMP, up: duty_new = min(duty+RAMP_STEP, target). Compute with a 9-bit intermediate; no overflow.
  - RAMP, down: duty_new = (duty ≤ target+RAMP_STEP) ? target : duty-RAMP_STEP.
  - RAMP, after the step: duty_new==target and target>0 → HOLD; duty_new==0 and target==0 → OFF; otherwise stay RAMP.
  - HOLD, target≠duty → RAMP, and the first step is applied at the same boundary.
- A target reversal during RAMP simply changes the step direction at the next boundary. There is no kick unless the state is OFF.
- at_target is combinational from registers: (state==OFF or HOLD) and duty==target.

Test Plan:
All scenarios use default parameters.
1. Reset release, speed_set=0 for 500 cycles → pwm_out=0 throughout; duty=0; drv_state=00; at_target=1.
2. From OFF, speed_set=1, fan_speed=01 → at the next boundary drv_state=01 and pwm_out high continuously for 400 cycles; then drv_state=11, duty=30, pwm_out high for 30 of every 100 cycles, at_target=1.
3. HOLD at 30, fan_speed=11 → duty 40,50,…,100 on 7 successive boundaries (drv_state=10); then drv_state=11 and pwm_out constant high.
4. HOLD at 100, fan_speed=00 → duty 90…0 over 10 boundaries; then drv_state=00 and pwm_out constant low. No kick is re-triggered.
5. HOLD at 30, then speed_set=0 with fan_speed=10 for 1000 cycles → duty stays 30. Asserting speed_set=1 at cnt=50 gives no duty change until that boundary, then duty=40.
6. reset pulled low at cnt=37 of the 2nd KICK period → pwm_out=0 asynchronously, before the next edge; all registers at reset values. After release, behaviour is identical to scenario 1.
